sprite_line_scanner: RTL and testbench
======================================

SPRITE_LINE_SCANNER -- requirements
Module: sprite_line_scanner

Interface
REQ-001 SHALL have parameter MAX_PER_LINE, default 64, meaning the maximum number of sprites emitted per scanline (range 1..128).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port line_start_i, input, 1 bit: a one-cycle pulse that starts a scan.
REQ-005 SHALL have port line_i, input, 10 bits: the scanline number, sampled on line_start_i.
REQ-006 SHALL have port ram_rd_addr_o, output, 8 bits: the sprite attribute RAM read address.
REQ-007 SHALL have port ram_rd_data_i, input, 32 bits: RAM read data, valid one cycle after its address.
REQ-008 SHALL have port busy_o, output, 1 bit: a scan is in progress.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse at scan end.
REQ-010 SHALL have ports spr_valid_o (output, 1 bit) and spr_ready_i (input, 1 bit): the descriptor handshake.
REQ-011 SHALL have descriptor outputs: spr_idx_o[6:0], spr_addr_o[11:0], spr_mode_o[0], spr_x_o[9:0], spr_row_o[5:0], spr_hflip_o, spr_z_o[1:0], spr_cmask_o[3:0], spr_pal_o[3:0], spr_width_o[1:0].
REQ-012 SHALL have port overflow_o, output, 1 bit: more visible sprites on this line than MAX_PER_LINE.

Function
REQ-013 SHALL treat sprite n as word pair 2n (addr[11:0], mode[15], x[25:16]) and 2n+1 (y[9:0], hflip[16], vflip[17], z[19:18], cmask[23:20], pal[27:24], width[29:28], height[31:30]).
REQ-014 SHALL use the FSM states IDLE, RD_A, RD_B, EVAL, EMIT and FIN.
REQ-015 SHALL, on line_start_i, latch line_i, clear the sprite index and emit count, and enter RD_A on the next cycle.
REQ-016 SHALL, in RD_A, drive address 2n; in RD_B, capture word A and drive 2n+1; in EVAL, evaluate using word B.
REQ-017 SHALL decode height as 8 << code, i.e. codes 0..3 give 8, 16, 32 and 64.
REQ-018 SHALL compute d = (line - y) mod 1024.
REQ-019 SHALL treat a sprite as visible when z != 0 and d < height.
REQ-020 SHALL output spr_row_o = d[5:0], or (height-1-d)[5:0] when vflip is set.
REQ-021 SHALL take 3 cycles per invisible sprite: EVAL goes to RD_A for n+1, or to FIN after n=127.
REQ-022 SHALL, for a visible sprite, go EVAL->EMIT and register the descriptor.
REQ-023 SHALL assert spr_valid_o in EMIT and hold the descriptor stable until spr_ready_i.
REQ-024 SHALL, on handshake, increment the emit count and advance as in REQ-021.
REQ-025 SHALL, in FIN, pulse done_o for one cycle and return to IDLE; busy_o is high in every state except IDLE.
REQ-026 SHALL, on line_start_i in any non-IDLE state, abort the scan, drop spr_valid_o the next cycle, and restart with the new line.
REQ-027 SHALL treat rst_i as taking priority over line_start_i.
REQ-028 SHALL, with all 128 sprites invisible, pulse done_o exactly 385 cycles after line_start_i.

Reset
REQ-029 SHALL, when rst_i is high, put the FSM in IDLE.
REQ-030 SHALL, while rst_i is high, clear busy_o, done_o, spr_valid_o and overflow_o, and clear ram_rd_addr_o, all descriptor outputs, the emit count and the index to 0.
REQ-031 SHALL, when rst_i is asserted mid-scan, discard a pending descriptor with no handshake.

Configuration
REQ-032 SHALL, with SPRITE_SCAN_OVERFLOW_EN defined, keep scanning in no-emit mode after the emit count reaches MAX_PER_LINE.
REQ-033 SHALL, with SPRITE_SCAN_OVERFLOW_EN defined, set overflow_o on any further visible sprite and hold it until the next line_start_i or reset.
REQ-034 SHALL, without SPRITE_SCAN_OVERFLOW_EN, go to FIN immediately after the MAX_PER_LINE-th handshake, with overflow_o tied to 0.

Structure
REQ-035 SHALL place the attribute bit-field positions, the height decode function, the FSM state enum and the NUM_SPRITES=128 constant in the shared package sprite_pkg.
REQ-036 SHALL put attribute word-pair decoding and the visibility/row computation in a combinational sub-module, sprite_attr_decode.

Verification
REQ-037 SHALL cover: RAM all zero, line 3 -> no spr_valid_o; done_o 385 cycles after start.
REQ-038 SHALL cover: all 128 sprites y=3, z=3, height 8, x=32*(2n), MAX_PER_LINE=64, ready held high, line 5 -> 64 descriptors, idx 0..63, row=2; with the macro, overflow_o=1.
REQ-039 SHALL cover: sprite 10 with y=1020, height 16, line 4 -> visible, row=8; line 12 -> not visible (wrap-around).
REQ-040 SHALL cover: sprite 0 with vflip, height 32, y=100, line 100 -> row=31; line 131 -> row=0; line 132 -> not emitted.
REQ-041 SHALL cover: spr_ready_i low for 20 cycles on the first descriptor -> outputs stable throughout; exactly one handshake; the next sprite is read afterwards.
REQ-042 SHALL cover: line_start_i mid-EMIT with line 7 -> spr_valid_o low the next cycle; the scan restarts from idx 0 with line 7.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scanner: sprite attribute word
// bit-field positions, the height decode helper, the scanner FSM state enum
// and the sprite table size.
package sprite_pkg;

  // Number of sprites in the attribute RAM (two 32-bit words per sprite).
  localparam int NUM_SPRITES = 128;

  // Word A (address 2n) field positions.
  localparam int A_ADDR_LSB  = 0;
  localparam int A_ADDR_MSB  = 11;
  localparam int A_MODE_BIT  = 15;
  localparam int A_X_LSB     = 16;
  localparam int A_X_MSB     = 25;

  // Word B (address 2n+1) field positions.
  localparam int B_Y_LSB      = 0;
  localparam int B_Y_MSB      = 9;
  localparam int B_HFLIP_BIT  = 16;
  localparam int B_VFLIP_BIT  = 17;
  localparam int B_Z_LSB      = 18;
  localparam int B_Z_MSB      = 19;
  localparam int B_CMASK_LSB  = 20;
  localparam int B_CMASK_MSB  = 23;
  localparam int B_PAL_LSB    = 24;
  localparam int B_PAL_MSB    = 27;
  localparam int B_WIDTH_LSB  = 28;
  localparam int B_WIDTH_MSB  = 29;
  localparam int B_HEIGHT_LSB = 30;
  localparam int B_HEIGHT_MSB = 31;

  // Scanner FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EVAL = 3'd3,
    EMIT = 3'd4,
    FIN  = 3'd5
  } scan_state_e;

  // Sprite height in lines: 8 << code, giving 8, 16, 32 or 64.
  function automatic logic [6:0] height_decode(input logic [1:0] code);
    logic [6:0] h;
    h = 7'd8 << code;
    return h;
  endfunction

endpackage

// File: rtl/sprite_attr_decode.sv
// Combinational decode of one sprite attribute word pair against the current
// scanline: extracts the descriptor fields and computes visibility and the
// source row (with vertical flip) inside the sprite.
module sprite_attr_decode
  import sprite_pkg::*;
(
  input  logic [31:0] word_a_i,
  input  logic [31:0] word_b_i,
  input  logic [9:0]  line_i,
  output logic [11:0] addr_o,
  output logic        mode_o,
  output logic [9:0]  x_o,
  output logic [5:0]  row_o,
  output logic        hflip_o,
  output logic [1:0]  z_o,
  output logic [3:0]  cmask_o,
  output logic [3:0]  pal_o,
  output logic [1:0]  width_o,
  output logic        visible_o
);

  logic [9:0] y_s;
  logic       vflip_s;
  logic [1:0] hcode_s;
  logic [9:0] height_s;
  logic [9:0] dist_s;
  logic [9:0] flip_row_s;
  logic       unused_bits_s;

  assign addr_o   = word_a_i[A_ADDR_MSB:A_ADDR_LSB];
  assign mode_o   = word_a_i[A_MODE_BIT];
  assign x_o      = word_a_i[A_X_MSB:A_X_LSB];

  assign y_s      = word_b_i[B_Y_MSB:B_Y_LSB];
  assign hflip_o  = word_b_i[B_HFLIP_BIT];
  assign vflip_s  = word_b_i[B_VFLIP_BIT];
  assign z_o      = word_b_i[B_Z_MSB:B_Z_LSB];
  assign cmask_o  = word_b_i[B_CMASK_MSB:B_CMASK_LSB];
  assign pal_o    = word_b_i[B_PAL_MSB:B_PAL_LSB];
  assign width_o  = word_b_i[B_WIDTH_MSB:B_WIDTH_LSB];
  assign hcode_s  = word_b_i[B_HEIGHT_MSB:B_HEIGHT_LSB];

  // Bits that carry no attribute information or fall outside the 6-bit row.
  assign unused_bits_s = ^{word_a_i[14:12], word_a_i[31:26], word_b_i[15:10],
                           dist_s[9:6], flip_row_s[9:6]};

  // Distance from sprite top wraps modulo 1024 so sprites near y=1023 can
  // straddle into the top lines of the frame.
  always_comb begin
    height_s   = {3'd0, height_decode(hcode_s)};
    dist_s     = line_i - y_s;
    flip_row_s = height_s - 10'd1 - dist_s;
    visible_o  = (z_o != 2'd0) && (dist_s < height_s);
    if (vflip_s) begin
      row_o = flip_row_s[5:0];
    end else begin
      row_o = dist_s[5:0];
    end
  end

endmodule

// File: rtl/sprite_line_scanner.sv
// Sprite line scanner: walks all 128 sprite attribute word pairs for one
// scanline, emitting a registered descriptor for every visible sprite over a
// valid/ready handshake.
// Optional feature macro: SPRITE_SCAN_OVERFLOW_EN -- when defined, the scan
// continues past MAX_PER_LINE emissions without emitting and flags further
// visible sprites on overflow_o; when undefined, the scan ends right after
// the MAX_PER_LINE-th handshake and overflow_o stays 0.
module sprite_line_scanner
  import sprite_pkg::*;
#(
  parameter int MAX_PER_LINE = 64
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  output logic [7:0]  ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_row_o,
  output logic        spr_hflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_cmask_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic        overflow_o
);

  scan_state_e state_q, state_d;
  logic [9:0]  line_q, line_d;
  logic [6:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] word_a_q, word_a_d;
  logic [7:0]  addr_q, addr_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, done_q, valid_q;
  logic        load_desc_s;

  // Registered descriptor.
  logic [6:0]  desc_idx_q;
  logic [11:0] desc_addr_q;
  logic        desc_mode_q;
  logic [9:0]  desc_x_q;
  logic [5:0]  desc_row_q;
  logic        desc_hflip_q;
  logic [1:0]  desc_z_q;
  logic [3:0]  desc_cmask_q;
  logic [3:0]  desc_pal_q;
  logic [1:0]  desc_width_q;

  // Decoded view of the current sprite (word B arrives straight from RAM in EVAL).
  logic [11:0] dec_addr_s;
  logic        dec_mode_s;
  logic [9:0]  dec_x_s;
  logic [5:0]  dec_row_s;
  logic        dec_hflip_s;
  logic [1:0]  dec_z_s;
  logic [3:0]  dec_cmask_s;
  logic [3:0]  dec_pal_s;
  logic [1:0]  dec_width_s;
  logic        dec_visible_s;

  logic        last_s;
  logic [6:0]  next_idx_s;
  logic        emit_ok_s;
  logic        stop_at_cap_s;
  logic        flag_ovf_s;

  sprite_attr_decode u_decode (
    .word_a_i  (word_a_q),
    .word_b_i  (ram_rd_data_i),
    .line_i    (line_q),
    .addr_o    (dec_addr_s),
    .mode_o    (dec_mode_s),
    .x_o       (dec_x_s),
    .row_o     (dec_row_s),
    .hflip_o   (dec_hflip_s),
    .z_o       (dec_z_s),
    .cmask_o   (dec_cmask_s),
    .pal_o     (dec_pal_s),
    .width_o   (dec_width_s),
    .visible_o (dec_visible_s)
  );

  assign last_s     = (idx_q == 7'(NUM_SPRITES - 1));
  assign next_idx_s = idx_q + 7'd1;

`ifdef SPRITE_SCAN_OVERFLOW_EN
  // Past the cap the scan keeps running but only records that more sprites exist.
  assign emit_ok_s     = (cnt_q < 8'(MAX_PER_LINE));
  assign stop_at_cap_s = 1'b0;
  assign flag_ovf_s    = 1'b1;
`else
  // The scan ends on the handshake that brings the count up to the cap.
  assign emit_ok_s     = 1'b1;
  assign stop_at_cap_s = (cnt_q == 8'(MAX_PER_LINE - 1));
  assign flag_ovf_s    = 1'b0;
`endif

  // Next-state logic; a line start restarts the scan from any state.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    word_a_d    = word_a_q;
    ovf_d       = ovf_q;
    load_desc_s = 1'b0;
    if (line_start_i) begin
      state_d = RD_A;
      line_d  = line_i;
      idx_d   = 7'd0;
      cnt_d   = 8'd0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RD_A: begin
          state_d = RD_B;
        end
        RD_B: begin
          word_a_d = ram_rd_data_i;
          state_d  = EVAL;
        end
        EVAL: begin
          if (dec_visible_s && emit_ok_s) begin
            load_desc_s = 1'b1;
            state_d     = EMIT;
          end else begin
            if (dec_visible_s && flag_ovf_s) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
            if (last_s) begin
              state_d = FIN;
            end else begin
              state_d = RD_A;
              idx_d   = next_idx_s;
            end
          end
        end
        EMIT: begin
          if (spr_ready_i) begin
            cnt_d = cnt_q + 8'd1;
            if (stop_at_cap_s || last_s) begin
              state_d = FIN;
            end else begin
              state_d = RD_A;
              idx_d   = next_idx_s;
            end
          end else begin
            state_d = EMIT;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // RAM address is registered so it presents word 2n in RD_A and 2n+1 in RD_B.
  always_comb begin
    addr_d = addr_q;
    case (state_d)
      RD_A:    addr_d = {idx_d, 1'b0};
      RD_B:    addr_d = {idx_q, 1'b1};
      default: addr_d = addr_q;
    endcase
  end

  // FSM state and scan bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      line_q   <= 10'd0;
      idx_q    <= 7'd0;
      cnt_q    <= 8'd0;
      word_a_q <= 32'd0;
      addr_q   <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      word_a_q <= word_a_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status flags and the descriptor, registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      desc_idx_q   <= 7'd0;
      desc_addr_q  <= 12'd0;
      desc_mode_q  <= 1'b0;
      desc_x_q     <= 10'd0;
      desc_row_q   <= 6'd0;
      desc_hflip_q <= 1'b0;
      desc_z_q     <= 2'd0;
      desc_cmask_q <= 4'd0;
      desc_pal_q   <= 4'd0;
      desc_width_q <= 2'd0;
    end else begin
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FIN);
      valid_q <= (state_d == EMIT);
      if (load_desc_s) begin
        desc_idx_q   <= idx_q;
        desc_addr_q  <= dec_addr_s;
        desc_mode_q  <= dec_mode_s;
        desc_x_q     <= dec_x_s;
        desc_row_q   <= dec_row_s;
        desc_hflip_q <= dec_hflip_s;
        desc_z_q     <= dec_z_s;
        desc_cmask_q <= dec_cmask_s;
        desc_pal_q   <= dec_pal_s;
        desc_width_q <= dec_width_s;
      end else begin
        desc_idx_q   <= desc_idx_q;
        desc_addr_q  <= desc_addr_q;
        desc_mode_q  <= desc_mode_q;
        desc_x_q     <= desc_x_q;
        desc_row_q   <= desc_row_q;
        desc_hflip_q <= desc_hflip_q;
        desc_z_q     <= desc_z_q;
        desc_cmask_q <= desc_cmask_q;
        desc_pal_q   <= desc_pal_q;
        desc_width_q <= desc_width_q;
      end
    end
  end

  assign ram_rd_addr_o = addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign spr_valid_o   = valid_q;
  assign overflow_o    = ovf_q;
  assign spr_idx_o     = desc_idx_q;
  assign spr_addr_o    = desc_addr_q;
  assign spr_mode_o    = desc_mode_q;
  assign spr_x_o       = desc_x_q;
  assign spr_row_o     = desc_row_q;
  assign spr_hflip_o   = desc_hflip_q;
  assign spr_z_o       = desc_z_q;
  assign spr_cmask_o   = desc_cmask_q;
  assign spr_pal_o     = desc_pal_q;
  assign spr_width_o   = desc_width_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Testbench for sprite_line_scanner: directed scans against a behavioural
// attribute RAM; expected descriptors go into a queue and a monitor compares
// them against every handshake the scanner makes.
module tb_sprite_line_scanner;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        line_start_i;
  logic [9:0]  line_i;
  logic [7:0]  ram_rd_addr_o;
  logic [31:0] ram_rd_data_i;
  logic        busy_o, done_o, spr_valid_o, spr_ready_i;
  logic [6:0]  spr_idx_o;
  logic [11:0] spr_addr_o;
  logic        spr_mode_o;
  logic [9:0]  spr_x_o;
  logic [5:0]  spr_row_o;
  logic        spr_hflip_o;
  logic [1:0]  spr_z_o;
  logic [3:0]  spr_cmask_o, spr_pal_o;
  logic [1:0]  spr_width_o;
  logic        overflow_o;

  logic [31:0] mem [0:255];
  logic [48:0] exp_q [$];
  logic [48:0] act_desc;
  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  sprite_line_scanner #(.MAX_PER_LINE(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .line_start_i(line_start_i), .line_i(line_i),
    .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
    .busy_o(busy_o), .done_o(done_o), .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i),
    .spr_idx_o(spr_idx_o), .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o), .spr_x_o(spr_x_o),
    .spr_row_o(spr_row_o), .spr_hflip_o(spr_hflip_o), .spr_z_o(spr_z_o), .spr_cmask_o(spr_cmask_o),
    .spr_pal_o(spr_pal_o), .spr_width_o(spr_width_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read attribute RAM: data for an address appears the next cycle.
  always @(posedge clk_i) ram_rd_data_i <= mem[ram_rd_addr_o];

  assign act_desc = {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o,
                     spr_hflip_o, spr_z_o, spr_cmask_o, spr_pal_o, spr_width_o};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wa(input logic [11:0] addr, input logic mode, input logic [9:0] x);
    return {6'd0, x, mode, 3'd0, addr};
  endfunction

  function automatic logic [31:0] wb(input logic [9:0] y, input logic hflip, input logic vflip,
                                     input logic [1:0] z, input logic [3:0] cmask, input logic [3:0] pal,
                                     input logic [1:0] width, input logic [1:0] hcode);
    return {hcode, width, pal, cmask, z, vflip, hflip, 6'd0, y};
  endfunction

  function automatic logic [48:0] mk_desc(input logic [6:0] idx, input logic [11:0] addr, input logic mode,
                                          input logic [9:0] x, input logic [5:0] row, input logic hflip,
                                          input logic [1:0] z, input logic [3:0] cmask, input logic [3:0] pal,
                                          input logic [1:0] width);
    return {idx, addr, mode, x, row, hflip, z, cmask, pal, width};
  endfunction

  // Scoreboard monitor: every handshake must match the oldest expected descriptor.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && spr_valid_o === 1'b1 && spr_ready_i === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_desc: got %0h expected no descriptor", act_desc);
      end else begin
        check("desc", 64'(act_desc), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic set_sprite(input int n, input logic [31:0] a, input logic [31:0] b);
    mem[2*n]   = a;
    mem[2*n+1] = b;
  endtask

  task automatic start_line(input logic [9:0] l);
    line_i       = l;
    line_start_i = 1'b1;
    tick();
    line_start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_o !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    if (done_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got done=%b expected done=1 within 1000 cycles", name, done_o);
    end
    tick();
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (spr_valid_o !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check(name, 64'(spr_valid_o), 64'd1);
  endtask

  initial begin
    int k;
    int hs0;
    logic [48:0] exp0;
    logic [63:0] ovf_exp;

    rst_i = 1'b1; line_start_i = 1'b0; line_i = 10'd0; spr_ready_i = 1'b1;
    clear_mem();

    // Reset state, sampled while reset is still applied.
    tick(); tick(); tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_valid", 64'(spr_valid_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_addr", 64'(ram_rd_addr_o), 64'd0);
    check("rst_desc", 64'(act_desc), 64'd0);
    rst_i = 1'b0;
    tick();
    check("idle_busy", 64'(busy_o), 64'd0);

    // Empty RAM, line 3: no descriptors, done 385 cycles after the start pulse.
    line_i = 10'd3; line_start_i = 1'b1; k = 0;
    while (k < 500) begin
      tick();
      k++;
      line_start_i = 1'b0;
      if (k == 1) check("busy_scan", 64'(busy_o), 64'd1);
      if (done_o === 1'b1) break;
    end
    check("done_latency", 64'(k), 64'd385);
    tick();
    check("done_pulse", 64'(done_o), 64'd0);
    check("idle_after", 64'(busy_o), 64'd0);

    // All 128 sprites visible on line 5: 64 emitted, row 2.
    for (int n = 0; n < 128; n++)
      set_sprite(n, wa(12'(n*16+5), n[0], 10'(64*n)),
                 wb(10'd3, n[1], 1'b0, 2'd3, n[3:0], ~n[3:0], n[1:0], 2'd0));
    for (int n = 0; n < 64; n++)
      exp_q.push_back(mk_desc(7'(n), 12'(n*16+5), n[0], 10'(64*n), 6'd2, n[1], 2'd3,
                              n[3:0], ~n[3:0], n[1:0]));
    start_line(10'd5);
    wait_done("full_line");
`ifdef SPRITE_SCAN_OVERFLOW_EN
    ovf_exp = 64'd1;
`else
    ovf_exp = 64'd0;
`endif
    check("overflow", 64'(overflow_o), ovf_exp);
    check("full_line_drained", 64'(exp_q.size()), 64'd0);

    // Wrap-around: y=1020, height 16.
    clear_mem();
    set_sprite(10, wa(12'hABC, 1'b1, 10'd300), wb(10'd1020, 1'b1, 1'b0, 2'd1, 4'h5, 4'hA, 2'd2, 2'd1));
    exp_q.push_back(mk_desc(7'd10, 12'hABC, 1'b1, 10'd300, 6'd8, 1'b1, 2'd1, 4'h5, 4'hA, 2'd2));
    start_line(10'd4);
    wait_done("wrap_vis");
    check("wrap_vis_drained", 64'(exp_q.size()), 64'd0);
    hs0 = hs_cnt;
    start_line(10'd12);
    wait_done("wrap_invis");
    check("wrap_invis_none", 64'(hs_cnt - hs0), 64'd0);

    // Vertical flip, height 32, y=100.
    clear_mem();
    set_sprite(0, wa(12'h123, 1'b0, 10'd17), wb(10'd100, 1'b0, 1'b1, 2'd2, 4'h3, 4'h7, 2'd1, 2'd2));
    exp_q.push_back(mk_desc(7'd0, 12'h123, 1'b0, 10'd17, 6'd31, 1'b0, 2'd2, 4'h3, 4'h7, 2'd1));
    start_line(10'd100);
    wait_done("vflip_top");
    exp_q.push_back(mk_desc(7'd0, 12'h123, 1'b0, 10'd17, 6'd0, 1'b0, 2'd2, 4'h3, 4'h7, 2'd1));
    start_line(10'd131);
    wait_done("vflip_bottom");
    hs0 = hs_cnt;
    start_line(10'd132);
    wait_done("vflip_below");
    check("vflip_below_none", 64'(hs_cnt - hs0), 64'd0);
    check("vflip_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: ready low for 20 cycles on the first descriptor.
    clear_mem();
    set_sprite(0, wa(12'h0F0, 1'b0, 10'd40), wb(10'd0, 1'b1, 1'b0, 2'd1, 4'h9, 4'h2, 2'd3, 2'd0));
    set_sprite(1, wa(12'h200, 1'b1, 10'd50), wb(10'd0, 1'b0, 1'b0, 2'd2, 4'h1, 4'h4, 2'd0, 2'd0));
    exp0 = mk_desc(7'd0, 12'h0F0, 1'b0, 10'd40, 6'd0, 1'b1, 2'd1, 4'h9, 4'h2, 2'd3);
    exp_q.push_back(exp0);
    exp_q.push_back(mk_desc(7'd1, 12'h200, 1'b1, 10'd50, 6'd0, 1'b0, 2'd2, 4'h1, 4'h4, 2'd0));
    spr_ready_i = 1'b0;
    hs0 = hs_cnt;
    start_line(10'd0);
    wait_valid("stall_first_valid");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", 64'(spr_valid_o), 64'd1);
      check("stall_desc", 64'(act_desc), 64'(exp0));
    end
    check("stall_no_hs", 64'(hs_cnt - hs0), 64'd0);
    spr_ready_i = 1'b1;
    tick();
    check("one_hs", 64'(hs_cnt - hs0), 64'd1);
    check("next_read_addr", 64'(ram_rd_addr_o), 64'd2);
    wait_done("stall");
    check("stall_total_hs", 64'(hs_cnt - hs0), 64'd2);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Abort during EMIT with a new line start.
    clear_mem();
    set_sprite(0, wa(12'h055, 1'b0, 10'd9), wb(10'd5, 1'b0, 1'b0, 2'd1, 4'hF, 4'h1, 2'd0, 2'd0));
    spr_ready_i = 1'b0;
    start_line(10'd5);
    wait_valid("abort_first_valid");
    check("abort_pre_row", 64'(spr_row_o), 64'd0);
    start_line(10'd7);
    check("abort_valid_drop", 64'(spr_valid_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd1);
    check("abort_restart_addr", 64'(ram_rd_addr_o), 64'd0);
    exp_q.push_back(mk_desc(7'd0, 12'h055, 1'b0, 10'd9, 6'd2, 1'b0, 2'd1, 4'hF, 4'h1, 2'd0));
    spr_ready_i = 1'b1;
    wait_done("abort");
    check("abort_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-EMIT discards the pending descriptor.
    spr_ready_i = 1'b0;
    hs0 = hs_cnt;
    start_line(10'd5);
    wait_valid("rst_mid_valid");
    rst_i = 1'b1;
    tick();
    check("rst_mid_valid_drop", 64'(spr_valid_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_x", 64'(spr_x_o), 64'd0);
    rst_i = 1'b0;
    spr_ready_i = 1'b1;
    tick(); tick();
    check("rst_mid_idle", 64'(busy_o), 64'd0);
    check("rst_mid_no_hs", 64'(hs_cnt - hs0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
